// File: rtl/aes_out_collector_pkg.sv
// Shared types for the AES result collector: job encoding, block width and FIFO entry layout.
package aes_out_collector_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ENCRYPT = 2'd0,
    DECRYPT = 2'd1,
    INVALID = 2'd2
  } job_t;

  typedef struct packed {
    job_t                 typ;
    logic [AES_BLK_W-1:0] data;
  } result_t;

  // Only the two real job types carry a result; every other encoding is idle.
  function automatic logic is_result(input job_t t);
    return (t == ENCRYPT) || (t == DECRYPT);
  endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and synchronous flush; no bypass path.
module aes_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 130,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Guards keep the pointers coherent even if a caller ignores full/empty.
  assign do_push = push && (count_q != LW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read from a slot before it is written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/aes_out_collector.sv
// Captures aes_engine results into a FIFO, backpressures the engine via halt, counts deliveries.
module aes_out_collector
  import aes_out_collector_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HALT_MARGIN = 0,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AES_BLK_W-1:0]   eng_out,
  input  job_t                   eng_out_type,
  output logic                   halt,
  input  logic                   flush,
  output logic [AES_BLK_W-1:0]   m_data,
  output job_t                   m_type,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       enc_done,
  output logic [CNT_W-1:0]       dec_done
);

  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int HALT_LVL = DEPTH - HALT_MARGIN;

  logic             eng_valid, push, pop;
  result_t          wr_res, rd_res;
  logic [LW-1:0]    level_w;
  logic [CNT_W-1:0] enc_q, enc_d;
  logic [CNT_W-1:0] dec_q, dec_d;

  // halt comes straight from the registered level, so the engine sees no comb path.
  assign halt      = level_w >= LW'(HALT_LVL);
  assign eng_valid = is_result(eng_out_type);
  assign push      = eng_valid && !halt;
  assign pop       = m_valid && m_ready;
  assign wr_res    = '{typ: eng_out_type, data: eng_out};

  aes_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(result_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .wr_data (wr_res),
    .pop     (pop),
    .rd_data (rd_res),
    .count   (level_w)
  );

  // Head is masked while empty so stale storage never leaks onto the port.
  assign m_valid = level_w != '0;
  assign m_data  = m_valid ? rd_res.data : '0;
  assign m_type  = m_valid ? rd_res.typ : INVALID;
  assign level   = level_w;

  always_comb begin
    enc_d = enc_q;
    dec_d = dec_q;
    if (pop && !flush) begin
      if (m_type == ENCRYPT) enc_d = enc_q + CNT_W'(1);
      if (m_type == DECRYPT) dec_d = dec_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_q <= '0;
      dec_q <= '0;
    end else begin
      enc_q <= enc_d;
      dec_q <= dec_d;
    end
  end

  assign enc_done = enc_q;
  assign dec_done = dec_q;

endmodule
